uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 36 +++
 rtl/uart_tx_arbiter_sync_edge_det.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: state encodings,
// requester count, grant constants and the round-robin pick helper.
package uart_tx_arbiter_pkg;

   localparam int         N_REQ              = 3;
   localparam logic [1:0] GRANT_NONE         = 2'd3;
   localparam int         TIMEOUT_CYCLES_DEF = 1024;

   // One-hot FSM encoding
   typedef enum logic [5:0] {
      ST_IDLE      = 6'b000001,
      ST_LOAD      = 6'b000010,
      ST_START     = 6'b000100,
      ST_WAIT_BUSY = 6'b001000,
      ST_WAIT_DONE = 6'b010000,
      ST_NEXT      = 6'b100000
   } state_t;

   // Round-robin winner: search begins one past the previous owner and
   // wraps modulo N_REQ; GRANT_NONE when nobody is requesting.
   function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                          input logic [1:0]       last);
      logic [1:0] cand;
      logic [1:0] pick;
      pick = GRANT_NONE;
      cand = last;
      for (int i = 0; i < N_REQ; i++) begin
         cand = (cand >= 2'd2) ? 2'd0 : cand + 2'd1;
         if ((pick == GRANT_NONE) && valid[cand]) begin
            pick = cand;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, with single-cycle
// rise/fall pulses derived from the synchronized value only.
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic prev;

   // Synchronizer chain plus one history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign dout = sync;
   assign rise = sync & ~prev;
   assign fall = ~sync & prev;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding bytes from three requesters
// to a single UART transmitter, with a watchdog on the busy handshake and
// on the gap between bytes of a packet.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]  req_last,
   output logic [N_REQ-1:0]  req_ack,
   output logic [7:0]        txd_data,
   output logic              txd_en_go,
   input  logic              txd_busy,
   output logic [1:0]        grant_id,
   output logic              timeout_err
);

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [1:0]  owner_q, owner_d;
   logic [1:0]  last_owner_q, last_owner_d;
   logic        last_flag_q;
   logic [7:0]  txd_data_q;
   logic [15:0] wdog_q;

   logic        busy_s, busy_rise, busy_fall;
   logic        load_en;
   logic        wd_hit;
   logic        owner_valid;
   logic [7:0]  owner_byte;
   logic        owner_last;

   sync_edge_det u_busy_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (txd_busy),
      .dout  (busy_s),
      .rise  (busy_rise),
      .fall  (busy_fall)
   );

   // Select the current owner's byte, last flag and valid
   always_comb begin
      owner_byte  = 8'd0;
      owner_last  = 1'b0;
      owner_valid = 1'b0;
      case (owner_q)
         2'd0: begin
            owner_byte  = req_data[7:0];
            owner_last  = req_last[0];
            owner_valid = req_valid[0];
         end
         2'd1: begin
            owner_byte  = req_data[15:8];
            owner_last  = req_last[1];
            owner_valid = req_valid[1];
         end
         2'd2: begin
            owner_byte  = req_data[23:16];
            owner_last  = req_last[2];
            owner_valid = req_valid[2];
         end
         default: begin
            owner_byte  = 8'd0;
            owner_last  = 1'b0;
            owner_valid = 1'b0;
         end
      endcase
   end

   // Next-state and output decode; watchdog expiry beats any other event
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      req_ack      = '0;
      txd_en_go    = 1'b0;
      timeout_err  = 1'b0;
      load_en      = 1'b0;
      wd_hit       = (wdog_q == WD_LAST);
      case (state_q)
         ST_IDLE: begin
            if (!busy_s && (|req_valid)) begin
               owner_d = rr_pick(req_valid, last_owner_q);
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            req_ack = 3'b001 << owner_q;
            load_en = 1'b1;
            state_d = ST_START;
         end
         ST_START: begin
            txd_en_go = 1'b1;
            state_d   = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (wd_hit) begin
               timeout_err  = 1'b1;
               last_owner_d = owner_q;
               owner_d      = GRANT_NONE;
               state_d      = ST_IDLE;
            end else if (busy_rise) begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (busy_fall) begin
               if (last_flag_q) begin
                  last_owner_d = owner_q;
                  owner_d      = GRANT_NONE;
                  state_d      = ST_IDLE;
               end else begin
                  state_d = ST_NEXT;
               end
            end
         end
         ST_NEXT: begin
            if (wd_hit) begin
               timeout_err  = 1'b1;
               last_owner_d = owner_q;
               owner_d      = GRANT_NONE;
               state_d      = ST_IDLE;
            end else if (owner_valid) begin
               state_d = ST_LOAD;
            end
         end
         default: begin
            owner_d = GRANT_NONE;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers: state, current owner and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= GRANT_NONE;
         last_owner_q <= 2'd2;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
      end
   end

   // Byte and last flag latched on leaving LOAD, held until the next LOAD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txd_data_q  <= 8'd0;
         last_flag_q <= 1'b0;
      end else if (load_en) begin
         txd_data_q  <= owner_byte;
         last_flag_q <= owner_last;
      end
   end

   // Watchdog restarts on every state change and runs in WAIT_BUSY/NEXT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q <= 16'd0;
      end else if (state_d != state_q) begin
         wdog_q <= 16'd0;
      end else if ((state_q == ST_WAIT_BUSY) || (state_q == ST_NEXT)) begin
         wdog_q <= wdog_q + 16'd1;
      end
   end

   assign txd_data = txd_data_q;
   assign grant_id = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a UART busy model
// and a monitor logging acks, transmitted bytes and watchdog pulses.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [23:0] req_data;
   logic [2:0]  req_last;
   logic [2:0]  req_ack;
   logic [7:0]  txd_data;
   logic        txd_en_go;
   logic        txd_busy;
   logic [1:0]  grant_id;
   logic        timeout_err;

   uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ack     (req_ack),
      .txd_data    (txd_data),
      .txd_en_go   (txd_en_go),
      .txd_busy    (txd_busy),
      .grant_id    (grant_id),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] q2[$];
   logic       busy_en = 1'b1;

   int         ack_q[$];
   logic [7:0] data_q[$];
   int         to_cnt   = 0;
   int         ack_viol = 0;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ack_sig(input int base);
      logic [31:0] s;
      s = 32'd0;
      for (int i = base; i < ack_q.size(); i++) s = (s << 4) | 32'(ack_q[i] + 1);
      return s;
   endfunction

   function automatic logic [31:0] data_sig(input int base);
      logic [31:0] s;
      s = 32'd0;
      for (int i = base; i < data_q.size(); i++) s = (s << 8) | {24'd0, data_q[i]};
      return s;
   endfunction

   // Requester side: present queue heads, pop one cycle after its ack
   task automatic drive_reqs();
      req_valid[0] = (q0.size() > 0);
      req_valid[1] = (q1.size() > 0);
      req_valid[2] = (q2.size() > 0);
      req_data[7:0]   = (q0.size() > 0) ? q0[0][7:0] : 8'd0;
      req_data[15:8]  = (q1.size() > 0) ? q1[0][7:0] : 8'd0;
      req_data[23:16] = (q2.size() > 0) ? q2[0][7:0] : 8'd0;
      req_last[0] = (q0.size() > 0) ? q0[0][8] : 1'b0;
      req_last[1] = (q1.size() > 0) ? q1[0][8] : 1'b0;
      req_last[2] = (q2.size() > 0) ? q2[0][8] : 1'b0;
   endtask

   initial begin
      logic [2:0] a;
      drive_reqs();
      forever begin
         @(negedge clk);
         a = req_ack;
         @(posedge clk);
         #1;
         if (a[0] && q0.size() > 0) void'(q0.pop_front());
         if (a[1] && q1.size() > 0) void'(q1.pop_front());
         if (a[2] && q2.size() > 0) void'(q2.pop_front());
         drive_reqs();
      end
   end

   // UART model: busy rises 3 cycles after a start pulse, lasts 20 cycles
   initial begin
      txd_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (txd_en_go && busy_en) begin
            repeat (3) @(posedge clk);
            #1 txd_busy = 1'b1;
            repeat (20) @(posedge clk);
            #1 txd_busy = 1'b0;
         end
      end
   end

   // Monitor: log acks, started bytes, watchdog pulses, ack shape errors
   initial begin
      logic [2:0] prev_ack;
      prev_ack = 3'd0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if ($countones(req_ack) > 1 || (req_ack != 3'd0 && prev_ack != 3'd0)) ack_viol++;
            if (req_ack[0]) ack_q.push_back(0);
            if (req_ack[1]) ack_q.push_back(1);
            if (req_ack[2]) ack_q.push_back(2);
            if (txd_en_go) data_q.push_back(txd_data);
            if (timeout_err) to_cnt++;
            prev_ack = req_ack;
         end else begin
            prev_ack = 3'd0;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_quiet(input string tag, input int budget);
      int n;
      n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && q2.size() == 0 &&
               grant_id == 2'd3 && !txd_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) check_vec(tag, 32'(n), 32'(budget - 1));
   endtask

   task automatic wait_acks(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while (ack_q.size() < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) check_vec(tag, 32'(ack_q.size()), 32'(target));
   endtask

   initial begin
      int ab, db, tb, i;
      rst_n = 1'b0;

      // Reset values while held
      repeat (2) @(negedge clk);
      check_vec("rst_ack",   32'(req_ack), 32'd0);
      check_vec("rst_engo",  32'(txd_en_go), 32'd0);
      check_vec("rst_to",    32'(timeout_err), 32'd0);
      check_vec("rst_data",  32'(txd_data), 32'd0);
      check_vec("rst_grant", 32'(grant_id), 32'd3);
      rst_n = 1'b1;

      // Single 2-byte packet from requester 0, with latency
      ab = ack_q.size(); db = data_q.size(); tb = to_cnt;
      q0.push_back({1'b0, 8'h34});
      q0.push_back({1'b1, 8'h12});
      @(negedge clk);
      check_vec("t1_ack_early", 32'(req_ack), 32'd0);
      @(negedge clk);
      check_vec("t1_ack_lat",   32'(req_ack), 32'd1);
      check_vec("t1_grant",     32'(grant_id), 32'd0);
      @(negedge clk);
      check_vec("t1_engo_lat",  32'(txd_en_go), 32'd1);
      check_vec("t1_data0",     32'(txd_data), 32'h34);
      wait_quiet("t1_wait", 300);
      check_vec("t1_acks",  ack_sig(ab), 32'h11);
      check_vec("t1_bytes", data_sig(db), 32'h3412);
      check_vec("t1_grant_end", 32'(grant_id), 32'd3);
      check_vec("t1_no_to", 32'(to_cnt - tb), 32'd0);

      // Contention after reset: order 0,1,2 then 0 again
      do_reset();
      ab = ack_q.size(); db = data_q.size();
      q0.push_back({1'b1, 8'h01});
      q1.push_back({1'b1, 8'h02});
      q2.push_back({1'b1, 8'h03});
      wait_quiet("t2_wait", 400);
      check_vec("t2_acks",  ack_sig(ab), 32'h123);
      check_vec("t2_bytes", data_sig(db), 32'h010203);
      ab = ack_q.size(); db = data_q.size();
      q0.push_back({1'b1, 8'h04});
      wait_quiet("t2_wait2", 200);
      check_vec("t2_reacks", ack_sig(ab), 32'h1);
      check_vec("t2_rebyte", data_sig(db), 32'h04);

      // Lock: requester 1 mid-packet keeps requester 0 waiting
      ab = ack_q.size(); db = data_q.size();
      q1.push_back({1'b0, 8'hB1});
      q1.push_back({1'b0, 8'hB2});
      q1.push_back({1'b1, 8'hB3});
      wait_acks("t3_first", ab + 1, 100);
      q0.push_back({1'b1, 8'hC0});
      wait_quiet("t3_wait", 600);
      check_vec("t3_acks",  ack_sig(ab), 32'h2221);
      check_vec("t3_bytes", data_sig(db), 32'hB1B2B3C0);

      // Busy never rises: watchdog after 16 cycles, then requester 1
      do_reset();
      busy_en = 1'b0;
      ab = ack_q.size(); db = data_q.size(); tb = to_cnt;
      q0.push_back({1'b1, 8'hA0});
      i = 0;
      while (!txd_en_go && i < 20) begin
         @(negedge clk);
         i++;
      end
      q1.push_back({1'b1, 8'hB1});
      for (i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (timeout_err) break;
      end
      check_vec("t4_to_cycle", 32'(i), 32'd16);
      check_vec("t4_to_noack", 32'(req_ack), 32'd0);
      busy_en = 1'b1;
      @(negedge clk);
      check_vec("t4_idle_grant", 32'(grant_id), 32'd3);
      wait_quiet("t4_wait", 300);
      check_vec("t4_acks",  ack_sig(ab), 32'h12);
      check_vec("t4_bytes", data_sig(db), 32'hA0B1);
      check_vec("t4_to_cnt", 32'(to_cnt - tb), 32'd1);

      // Owner withholds its next byte: NEXT watchdog
      ab = ack_q.size(); db = data_q.size(); tb = to_cnt;
      q0.push_back({1'b0, 8'h55});
      wait_quiet("t5_wait", 300);
      repeat (20) @(negedge clk);
      check_vec("t5_to_cnt", 32'(to_cnt - tb), 32'd1);
      check_vec("t5_acks",   ack_sig(ab), 32'h1);
      check_vec("t5_bytes",  data_sig(db), 32'h55);

      // Reset in WAIT_DONE: immediate reset values, then requester 0 first
      q0.push_back({1'b1, 8'h77});
      wait_quiet("t6_pre", 200);
      q1.push_back({1'b0, 8'h88});
      q1.push_back({1'b1, 8'h99});
      i = 0;
      while (!(grant_id == 2'd1 && txd_busy) && i < 60) begin
         @(negedge clk);
         i++;
      end
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      q1.delete();
      #1;
      check_vec("t6_ack",   32'(req_ack), 32'd0);
      check_vec("t6_engo",  32'(txd_en_go), 32'd0);
      check_vec("t6_to",    32'(timeout_err), 32'd0);
      check_vec("t6_data",  32'(txd_data), 32'd0);
      check_vec("t6_grant", 32'(grant_id), 32'd3);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_quiet("t6_settle", 100);
      ab = ack_q.size();
      q0.push_back({1'b1, 8'h5A});
      q1.push_back({1'b1, 8'h6B});
      wait_quiet("t6_wait", 300);
      check_vec("t6_acks", ack_sig(ab), 32'h12);

      check_vec("ack_shape", 32'(ack_viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
